// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 4;
endpackage

// File: rtl/uart_rx_sync.sv
// SYNC_LEN-deep synchroniser for the asynchronous rx pad; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [SYNC_LEN-1:0] ff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ff <= '1;
    else         ff <= {ff[SYNC_LEN-2:0], d};
  end

  assign q = ff[SYNC_LEN-1];
endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with valid/ready holding register, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int SYNC_LEN = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [DIV_W-1:0]          divisor,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      parity_err
);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e            state, state_n;
  logic [DIV_W-1:0]          cnt, div_l, half_m1;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s, par_bad, last;
  logic                      cnt_clr, latch, start_ok, shift, deliver, fe, pe;

  uart_rx_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx),
    .q      (rx_s)
  );

  assign half_m1 = (div_l >> 1) - DIV_W'(1);
  assign last    = (cnt == div_l - DIV_W'(1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    latch    = 1'b0;
    start_ok = 1'b0;
    shift    = 1'b0;
    deliver  = 1'b0;
    fe       = 1'b0;
    pe       = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          latch   = 1'b1;
          state_n = START;
        end
      end
      // Mid-start-bit recheck rejects glitches shorter than half a bit.
      START: if (cnt == half_m1) begin
        cnt_clr = 1'b1;
        if (rx_s) state_n = IDLE;
        else begin
          start_ok = 1'b1;
          state_n  = DATA;
        end
      end
      DATA: if (last) begin
        cnt_clr = 1'b1;
        shift   = 1'b1;
        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (last) begin
        cnt_clr = 1'b1;
        pe      = (^shreg) ^ rx_s;
        state_n = STOP;
      end
`endif
      STOP: if (last) begin
        cnt_clr = 1'b1;
        if (rx_s) begin
          deliver = !par_bad;
          state_n = IDLE;
        end else begin
          fe      = 1'b1;
          state_n = BREAK;
        end
      end
      // Held-low line: wait for idle so a long break reports only once.
      BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      div_l      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_clr ? '0 : cnt + DIV_W'(1);
      frame_err <= fe;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= pe;
`else
      parity_err <= 1'b0;
`endif
      if (latch) begin
        div_l   <= divisor;
        par_bad <= 1'b0;
      end else if (pe) begin
        par_bad <= 1'b1;
      end
      if (start_ok)   bit_idx <= '0;
      else if (shift) bit_idx <= bit_idx + 3'd1;
      if (shift) shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
      // A consumer handshake in the delivery cycle frees the slot for the new byte.
      if (deliver) begin
        if (valid && !ready) overrun <= 1'b1;
        else begin
          data  <= shreg;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: serial frames in, expected bytes queued and matched on handshake.
module tb_uart_rx_core;
  localparam int DIV = 218;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] divisor = 16'(DIV);
  logic        rx = 1'b1;
  logic        ready = 1'b1;
  logic [7:0]  data;
  logic        valid, busy, frame_err, overrun, parity_err;

  int n_chk = 0, n_fail = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0;
  logic [7:0] sb[$];

  uart_rx_core dut (
    .clk        (clk),
    .resetn     (resetn),
    .divisor    (divisor),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    fe_n += int'(frame_err);
    ov_n += int'(overrun);
    pe_n += int'(parity_err);
    if (valid && ready) begin
      if (sb.size() > 0) chk("rx_data", {24'd0, data}, {24'd0, sb.pop_front()});
      else               chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
    end
  end

  task automatic bit_out(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    bit_out(1'b0, DIV);
    for (int i = 0; i < 8; i++) bit_out(b[i], DIV);
`ifdef UART_RX_PARITY_EN
    bit_out((^b) ^ par_flip, DIV);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    bit_out(stop_bit, DIV);
    if (stop_bit) bit_out(1'b1, 20);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog expired t=%0t", $time);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, pe0;
    // Reset state
    idle(3);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    resetn = 1'b1;
    idle(10);

    // 1: two back-to-back bytes, consumer always ready
    fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
    sb.push_back(8'h55); send_frame(8'h55, 1'b1, 1'b0);
    sb.push_back(8'hA3); send_frame(8'hA3, 1'b1, 1'b0);
    idle(300);
    chk("t1_drained", sb.size(), 32'd0);
    chk("t1_valid", {31'd0, valid}, 32'd0);
    chk("t1_err", fe_n - fe0 + ov_n - ov0 + pe_n - pe0, 32'd0);

    // 2: short low glitch is a false start
    bit_out(1'b0, 50);
    chk("t2_busy_hi", {31'd0, busy}, 32'd1);
    bit_out(1'b1, 100);
    chk("t2_busy_lo", {31'd0, busy}, 32'd0);
    chk("t2_no_valid", {31'd0, valid}, 32'd0);

    // 3: bad stop bit, then line held low: single frame_err
    fe0 = fe_n;
    send_frame(8'h41, 1'b0, 1'b0);
    idle(5000);
    bit_out(1'b1, 300);
    chk("t3_fe_once", fe_n - fe0, 32'd1);
    chk("t3_no_valid", {31'd0, valid}, 32'd0);
    sb.push_back(8'h5A); send_frame(8'h5A, 1'b1, 1'b0);
    idle(300);
    chk("t3_recover", sb.size(), 32'd0);

    // 4: consumer stalled, second byte overruns
    ready = 1'b0; ov0 = ov_n;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(300);
    chk("t4_valid_held", {31'd0, valid}, 32'd1);
    chk("t4_data_held", {24'd0, data}, 32'h11);
    chk("t4_overrun", ov_n - ov0, 32'd1);
    ready = 1'b1;
    idle(3);
    chk("t4_drained", sb.size(), 32'd0);
    chk("t4_valid_drop", {31'd0, valid}, 32'd0);

    // 5: handshake of old byte in the same cycle as delivery of the new one
    ready = 1'b0; ov0 = ov_n;
    sb.push_back(8'h7E); sb.push_back(8'h7F);
    fork
      begin
        send_frame(8'h7E, 1'b1, 1'b0);
        send_frame(8'h7F, 1'b1, 1'b0);
      end
      begin
        @(posedge busy);
        @(negedge busy);
        @(posedge busy);
        // delivery lands half + 9*DIV edges after the start edge
        repeat (DIV / 2 + 9 * DIV - 1) @(posedge clk);
        #1 ready = 1'b1;
      end
    join
    idle(300);
    chk("t5_drained", sb.size(), 32'd0);
    chk("t5_no_overrun", ov_n - ov0, 32'd0);

    // 6: reset in the middle of bit 4, then resend
    bit_out(1'b0, DIV);
    for (int i = 0; i < 4; i++) bit_out(1'(8'h33 >> i), DIV);
    bit_out(1'b1, DIV / 2);
    resetn = 1'b0;
    #2;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_valid", {31'd0, valid}, 32'd0);
    chk("t6_rst_data", {24'd0, data}, 32'd0);
    rx = 1'b1;
    idle(10);
    resetn = 1'b1;
    idle(300);
    chk("t6_no_partial", {31'd0, valid}, 32'd0);
    sb.push_back(8'h33); send_frame(8'h33, 1'b1, 1'b0);
    idle(300);
    chk("t6_resend", sb.size(), 32'd0);
`ifdef UART_RX_PARITY_EN
    pe0 = pe_n;
    send_frame(8'h33, 1'b1, 1'b1);
    idle(300);
    chk("t6_parity_err", pe_n - pe0, 32'd1);
    chk("t6_par_no_valid", {31'd0, valid}, 32'd0);
`else
    chk("t6_parity_tied", pe_n - pe0, 32'd0);
`endif

    chk("final_sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
